// File: rtl/ifu_pkg.sv
// Types and constants for the instruction fetch unit.
package ifu_pkg;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] data;
  } ifu_entry_t;

  localparam int ENTRY_W = $bits(ifu_entry_t);
endpackage

// File: rtl/pc_pkg.sv
// Shared constants for the program-counter register and its clients.
package pc_pkg;
  localparam logic        PC_ENABLED       = 1'b1;
  localparam logic [31:0] PC_START_ADDRESS = 32'h0000_1000;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs for decode.
module ifu_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: drives the PC register, fetches words from
// instruction memory one at a time and buffers them for decode.
module ifu
  import ifu_pkg::*;
  import pc_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] curr_pc,
  output logic [31:0] next_pc,
  output logic        pc_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  ifu_state_e  r_state;
  logic [31:0] r_pend_pc;
  logic        r_fault;

  logic          w_misaligned;
  logic          w_redirect_ok;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  ifu_entry_t    w_push_entry;
  ifu_entry_t    w_head;

  assign w_misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_redirect_ok = redirect_valid && !w_misaligned;

  assign imem_req_addr  = curr_pc;
  assign imem_req_valid = !rst && (r_state == ST_FETCH) && (w_count < CW'(BUF_DEPTH))
                          && !redirect_valid && !r_fault;
  assign w_accept       = imem_req_valid && imem_req_ready;

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    pc_enable = !PC_ENABLED;
    next_pc   = curr_pc;
    if (!rst) begin
      if (w_redirect_ok) begin
        pc_enable = PC_ENABLED;
        next_pc   = redirect_pc;
      end else if (w_accept) begin
        pc_enable = PC_ENABLED;
        next_pc   = curr_pc + 32'd4;
      end
    end
  end

  // A response that races a redirect is stale and never reaches the buffer.
  assign w_push       = (r_state == ST_WAIT) && imem_resp_valid && !redirect_valid && !w_full;
  assign w_pop        = inst_valid && inst_ready;
  assign w_push_entry = '{pc: r_pend_pc, data: imem_resp_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_pend_pc <= '0;
      r_fault   <= 1'b0;
    end else begin
      if (w_misaligned) r_fault <= 1'b1;
      case (r_state)
        ST_FETCH: begin
          if (w_accept) begin
            r_pend_pc <= curr_pc;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid)     r_state <= ST_FETCH;
          else if (redirect_valid) r_state <= ST_DROP;
        end
        ST_DROP: begin
          if (imem_resp_valid) r_state <= ST_FETCH;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  ifu_fifo #(
    .DEPTH(BUF_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .push_data(w_push_entry),
    .pop      (w_pop),
    .flush    (redirect_valid),
    .head_data(w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count)
  );

  assign inst_valid  = !w_empty;
  assign inst_pc     = w_head.pc;
  assign inst_data   = w_head.data;
  assign fetch_fault = r_fault;
endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed corner cases plus a randomized phase
// checked against an in-order instruction-stream reference model.
module tb_ifu;
  import pc_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] curr_pc;
  logic [31:0] next_pc;
  logic        pc_enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  int n_assert = 0;
  int n_fail   = 0;

  // Memory model state
  bit          mem_pend = 0;
  logic [31:0] mem_addr = '0;
  int          mem_lat  = 1;
  int          lat      = 1;

  // Reference model: next address expected at decode and at the request port
  logic [31:0] exp_addr   = PC_START_ADDRESS;
  logic [31:0] fetch_addr = PC_START_ADDRESS;
  bit          prev_redirect = 0;
  int          n_pop  = 0;
  int          n_reqv = 0;
  bit          last_acc = 0;
  bit          last_pop = 0;
  logic [31:0] last_pop_pc = '0;

  ifu #(.BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .curr_pc        (curr_pc),
    .next_pc        (next_pc),
    .pc_enable      (pc_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register: synchronous reset, loads next_pc when enabled
  always @(posedge clk) begin
    if (rst) curr_pc <= PC_START_ADDRESS;
    else if (pc_enable == PC_ENABLED) curr_pc <= next_pc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observe the settled cycle, advance one clock, then drive the memory response.
  task automatic cycle();
    logic acc;
    logic pop;
    acc = imem_req_valid && imem_req_ready;
    pop = inst_valid && inst_ready;
    last_acc = 0;
    last_pop = 0;
    if (rst) begin
      exp_addr      = PC_START_ADDRESS;
      fetch_addr    = PC_START_ADDRESS;
      prev_redirect = 0;
    end else begin
      if (prev_redirect) check("inst_valid_after_redirect", {31'b0, inst_valid}, 32'd0);
      if (imem_req_valid) n_reqv++;
      if (acc) begin
        check("single_outstanding", {31'b0, mem_pend}, 32'd0);
        check("fetch_addr", imem_req_addr, fetch_addr);
        fetch_addr = fetch_addr + 32'd4;
        mem_pend = 1;
        mem_addr = imem_req_addr;
        mem_lat  = lat;
        last_acc = 1;
      end
      if (pop) begin
        check("inst_pc", inst_pc, exp_addr);
        check("inst_data", inst_data, ~exp_addr);
        exp_addr    = exp_addr + 32'd4;
        n_pop++;
        last_pop    = 1;
        last_pop_pc = inst_pc;
      end
      if (redirect_valid && redirect_pc[1:0] == 2'b00) begin
        exp_addr   = redirect_pc;
        fetch_addr = redirect_pc;
      end
      prev_redirect = redirect_valid;
    end
    @(posedge clk);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (mem_pend) begin
      if (mem_lat <= 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = ~mem_addr;
        mem_pend = 0;
      end else begin
        mem_lat--;
      end
    end
    #1;
  endtask

  task automatic wait_acc();
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_acc) break;
    end
    check("wait_acc", {31'b0, last_acc}, 32'd1);
  endtask

  task automatic wait_pop();
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_pop) break;
    end
    check("wait_pop", {31'b0, last_pop}, 32'd1);
  endtask

  initial begin
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b1;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_pc_enable", {31'b0, pc_enable}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Streaming: one instruction per two cycles
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, PC_START_ADDRESS);
    check("first_pc_enable", {31'b0, pc_enable}, 32'd1);
    check("first_next_pc", next_pc, PC_START_ADDRESS + 32'd4);
    n_pop = 0;
    repeat (12) cycle();
    check("stream_pops", n_pop, 32'd5);

    // Back-pressure fills the two-entry buffer and stalls fetch
    inst_ready = 1'b0;
    #1;
    repeat (6) cycle();
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("stall_pc_enable", {31'b0, pc_enable}, 32'd0);
    check("stall_next_pc", next_pc, curr_pc);
    check("stall_curr_pc", curr_pc, fetch_addr);
    check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    #1;
    repeat (10) cycle();

    // Redirect while waiting; the stale response arrives 3 cycles after acceptance
    lat = 3;
    wait_acc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    #1;
    check("redir_wait_pc_enable", {31'b0, pc_enable}, 32'd1);
    check("redir_wait_next_pc", next_pc, 32'h0000_4000);
    check("redir_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("drop_req_valid", {31'b0, imem_req_valid}, 32'd0);
    wait_pop();
    check("redir_wait_first_pc", last_pop_pc, 32'h0000_4000);

    // Redirect coincident with the response
    lat = 2;
    wait_acc();
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5000;
    #1;
    check("redir_resp_next_pc", next_pc, 32'h0000_5000);
    check("redir_resp_pc_enable", {31'b0, pc_enable}, 32'd1);
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("redir_resp_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("redir_resp_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("redir_resp_req_addr", imem_req_addr, 32'h0000_5000);
    wait_pop();
    check("redir_resp_first_pc", last_pop_pc, 32'h0000_5000);

    // PC wrap at the top of the address space
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    cycle();
    redirect_valid = 1'b0;
    #1;
    for (int k = 0; k < 10 && !imem_req_valid; k++) cycle();
    check("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_next_pc", next_pc, 32'h0000_0000);
    check("wrap_pc_enable", {31'b0, pc_enable}, 32'd1);
    repeat (8) cycle();

    // Randomized traffic against the stream model
    for (int i = 0; i < 400; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      lat            = $urandom_range(1, 4);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      #1;
      cycle();
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    #1;

    // Misaligned redirect: sticky fault, PC held, no further requests
    lat = 2;
    wait_acc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4002;
    #1;
    check("misalign_pc_enable", {31'b0, pc_enable}, 32'd0);
    check("misalign_next_pc", next_pc, curr_pc);
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("misalign_fault", {31'b0, fetch_fault}, 32'd1);
    check("misalign_inst_valid", {31'b0, inst_valid}, 32'd0);
    n_reqv = 0;
    repeat (10) cycle();
    check("misalign_no_reqs", n_reqv, 32'd0);
    check("misalign_fault_sticky", {31'b0, fetch_fault}, 32'd1);

    // Asynchronous reset clears the fault immediately
    #2;
    rst = 1'b1;
    #1;
    check("arst_fault", {31'b0, fetch_fault}, 32'd0);
    check("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    repeat (2) cycle();
    rst = 1'b0;
    #1;

    // Asynchronous reset in WAIT; the late response must be ignored
    lat = 3;
    wait_acc();
    #2;
    rst = 1'b1;
    #1;
    check("arst_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("arst_wait_pc_enable", {31'b0, pc_enable}, 32'd0);
    check("arst_wait_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("arst_wait_fault", {31'b0, fetch_fault}, 32'd0);
    repeat (2) cycle();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    check("late_resp_req_valid", {31'b0, imem_req_valid}, 32'd1);
    cycle();
    check("late_resp_inst_valid", {31'b0, inst_valid}, 32'd0);
    imem_req_ready = 1'b1;
    #1;
    wait_pop();
    check("post_reset_first_pc", last_pop_pc, PC_START_ADDRESS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
